// File: rtl/pc_gen_mt.sv
// Multi-thread PC generator: one PC per thread, round-robin fetch slot with a valid/ready handshake,
// per-thread branch/trap redirects with stale-request flush and misaligned-branch reporting.
module pc_gen_mt #(
    parameter int unsigned              CPU_WIDTH  = 32,
    parameter logic [CPU_WIDTH-1:0]     RESET_PC   = '0,
    parameter int unsigned              THREAD_NUM = 2,
    parameter int unsigned              PC_STEP    = 4,
    localparam int unsigned             TID_W      = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [THREAD_NUM-1:0] thread_en,
    input  logic [THREAD_NUM-1:0] halt,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [CPU_WIDTH-1:0]  fetch_pc,
    output logic [TID_W-1:0]      fetch_tid,
    input  logic                  br_valid,
    input  logic [TID_W-1:0]      br_tid,
    input  logic [CPU_WIDTH-1:0]  br_pc,
    input  logic                  trap_valid,
    input  logic [TID_W-1:0]      trap_tid,
    input  logic [CPU_WIDTH-1:0]  trap_pc,
    output logic                  misalign_err,
    output logic [TID_W-1:0]      misalign_tid
);

    localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = CPU_WIDTH'(PC_STEP - 1);
    localparam logic [CPU_WIDTH-1:0] STEP       = CPU_WIDTH'(PC_STEP);
    localparam logic [TID_W:0]       NUM_EXT    = (TID_W + 1)'(THREAD_NUM);
    localparam logic [TID_W-1:0]     LAST_TID   = TID_W'(THREAD_NUM - 1);

    logic [CPU_WIDTH-1:0]  pc_q [THREAD_NUM];
    logic [TID_W-1:0]      rr_q;
    logic                  valid_q;
    logic [CPU_WIDTH-1:0]  fetch_pc_q;
    logic [TID_W-1:0]      fetch_tid_q;
    logic                  mis_q;
    logic [TID_W-1:0]      mis_tid_q;

    logic                    br_aligned;
    logic [THREAD_NUM-1:0]   trap_hit, br_hit, redir, elig;
    logic [2*THREAD_NUM-1:0] elig_rot;
    logic [TID_W-1:0]        off, sel, rr_next;
    logic [TID_W:0]          sel_sum;
    logic                    found, load, flush, mis_d;

    always_comb begin
        br_aligned = (br_pc & ALIGN_MASK) == '0;
        for (int t = 0; t < int'(THREAD_NUM); t++) begin
            trap_hit[t] = trap_valid && (trap_tid == TID_W'(t));
            // A trap on the same thread overrides the branch.
            br_hit[t]   = br_valid && br_aligned && (br_tid == TID_W'(t)) && !trap_hit[t];
            redir[t]    = trap_hit[t] || br_hit[t];
            elig[t]     = thread_en[t] && !halt[t] && !redir[t];
        end

        // Rotate so bit 0 is the thread at rr_q, then take the lowest set bit.
        elig_rot = {elig, elig} >> rr_q;
        off      = '0;
        for (int i = int'(THREAD_NUM) - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                off = TID_W'(i);
            end
        end
        found   = |elig;
        sel_sum = {1'b0, rr_q} + {1'b0, off};
        if (sel_sum >= NUM_EXT) begin
            sel_sum = sel_sum - NUM_EXT;
        end
        sel     = sel_sum[TID_W-1:0];
        rr_next = (sel == LAST_TID) ? '0 : sel + 1'b1;

        load  = (!valid_q || fetch_ready) && found;
        flush = valid_q && !fetch_ready && redir[fetch_tid_q];
        mis_d = br_valid && !br_aligned && !(trap_valid && (trap_tid == br_tid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < int'(THREAD_NUM); t++) begin
                pc_q[t] <= RESET_PC;
            end
            rr_q        <= '0;
            valid_q     <= 1'b0;
            fetch_pc_q  <= '0;
            fetch_tid_q <= '0;
            mis_q       <= 1'b0;
            mis_tid_q   <= '0;
        end else begin
            for (int t = 0; t < int'(THREAD_NUM); t++) begin
                if (trap_hit[t]) begin
                    pc_q[t] <= trap_pc & ~ALIGN_MASK;
                end else if (br_hit[t]) begin
                    pc_q[t] <= br_pc;
                end else if (load && (sel == TID_W'(t))) begin
                    pc_q[t] <= pc_q[t] + STEP;
                end
            end
            if (load) begin
                valid_q     <= 1'b1;
                fetch_pc_q  <= pc_q[sel];
                fetch_tid_q <= sel;
                rr_q        <= rr_next;
            end else if (fetch_ready || flush) begin
                valid_q <= 1'b0;
            end
            mis_q <= mis_d;
            if (mis_d) begin
                mis_tid_q <= br_tid;
            end
        end
    end

    assign fetch_valid  = valid_q;
    assign fetch_pc     = fetch_pc_q;
    assign fetch_tid    = fetch_tid_q;
    assign misalign_err = mis_q;
    assign misalign_tid = mis_tid_q;

endmodule

// File: tb/tb_pc_gen_mt.sv
// Bench for pc_gen_mt (2 threads, step 4): directed vector table, then random stimulus
// checked against a behavioural model of the PC generator.
module tb_pc_gen_mt;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  thread_en, halt;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic [0:0]  fetch_tid;
    logic        br_valid;
    logic [0:0]  br_tid;
    logic [31:0] br_pc;
    logic        trap_valid;
    logic [0:0]  trap_tid;
    logic [31:0] trap_pc;
    logic        misalign_err;
    logic [0:0]  misalign_tid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_gen_mt #(
        .CPU_WIDTH (32),
        .RESET_PC  (32'h0000_0000),
        .THREAD_NUM(2),
        .PC_STEP   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .thread_en   (thread_en),
        .halt        (halt),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_tid   (fetch_tid),
        .br_valid    (br_valid),
        .br_tid      (br_tid),
        .br_pc       (br_pc),
        .trap_valid  (trap_valid),
        .trap_tid    (trap_tid),
        .trap_pc     (trap_pc),
        .misalign_err(misalign_err),
        .misalign_tid(misalign_tid)
    );

    typedef struct {
        logic        r;
        logic [1:0]  en;
        logic [1:0]  hl;
        logic        rdy;
        logic        bv;
        logic        bt;
        logic [31:0] bp;
        logic        tv;
        logic        tt;
        logic [31:0] tp;
        logic        ev;
        logic [31:0] epc;
        logic        et;
        logic        em;
        logic        emt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [1:0] en, logic [1:0] hl, logic rdy,
                                logic bv, logic bt, logic [31:0] bp,
                                logic tv, logic tt, logic [31:0] tp,
                                logic ev, logic [31:0] epc, logic et, logic em, logic emt);
        vec_t v;
        v.r = r; v.en = en; v.hl = hl; v.rdy = rdy;
        v.bv = bv; v.bt = bt; v.bp = bp; v.tv = tv; v.tt = tt; v.tp = tp;
        v.ev = ev; v.epc = epc; v.et = et; v.em = em; v.emt = emt;
        return v;
    endfunction

    // Behavioural model state
    logic [31:0] m_pc [N];
    int          m_rr;
    logic        m_valid;
    logic [31:0] m_fpc;
    int          m_ftid;
    logic        m_mis;
    int          m_mis_tid;

    task automatic model_step();
        bit th [N];
        bit bh [N];
        bit el [N];
        bit found, aligned, mis, flush;
        int sel;
        if (rst) begin
            for (int t = 0; t < N; t++) m_pc[t] = 32'h0;
            m_rr = 0; m_valid = 0; m_fpc = 0; m_ftid = 0; m_mis = 0; m_mis_tid = 0;
            return;
        end
        aligned = (br_pc % 4) == 0;
        for (int t = 0; t < N; t++) begin
            th[t] = trap_valid && (int'(trap_tid) == t);
            bh[t] = br_valid && aligned && (int'(br_tid) == t) && !th[t];
            el[t] = thread_en[t] && !halt[t] && !th[t] && !bh[t];
        end
        found = 0;
        sel   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && el[(m_rr + k) % N]) begin
                found = 1;
                sel   = (m_rr + k) % N;
            end
        end
        flush = m_valid && !fetch_ready && (th[m_ftid] || bh[m_ftid]);
        mis   = br_valid && !aligned && !(trap_valid && trap_tid == br_tid);
        if ((!m_valid || fetch_ready) && found) begin
            m_valid  = 1;
            m_fpc    = m_pc[sel];
            m_ftid   = sel;
            m_pc[sel] = m_pc[sel] + 32'd4;
            m_rr     = (sel + 1) % N;
        end else if (fetch_ready || flush) begin
            m_valid = 0;
        end
        for (int t = 0; t < N; t++) begin
            if (th[t]) m_pc[t] = trap_pc & ~32'h3;
            else if (bh[t]) m_pc[t] = br_pc;
        end
        m_mis = mis;
        if (mis) m_mis_tid = int'(br_tid);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; thread_en = v.en; halt = v.hl; fetch_ready = v.rdy;
        br_valid = v.bv; br_tid = v.bt; br_pc = v.bp;
        trap_valid = v.tv; trap_tid = v.tt; trap_pc = v.tp;
    endtask

    initial begin
        //              r  en hl rdy bv bt bp            tv tt tp             ev epc           et em emt
        vecs.push_back(mk(1, 3, 0, 1, 0, 0, 0,           0, 0, 0,           0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h4,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0,           0, 0, 0,           1, 32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0,           0, 0, 0,           1, 32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0,           0, 0, 0,           1, 32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h8,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h8,        1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 1, 1, 32'h100,     0, 0, 0,           0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0,           0, 0, 0,           1, 32'hC,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h100,      1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h10,       0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h104,      1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 1, 0, 32'h400,     1, 0, 32'h203,     1, 32'h108,      1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h200,      0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 1, 1, 32'h102,     0, 0, 0,           1, 32'h10C,      1, 1, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h204,      0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h110,      1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,           1, 0, 32'hFFFF_FFFC, 0, 32'h0,      0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0,           0, 0, 0,           0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 3, 1, 1, 0, 0, 0,           0, 0, 0,           1, 32'h4,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,           0, 0, 0,           0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           0, 0, 0,           0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0,           0, 0, 0,           1, 32'h4,        0, 0, 0));

        drive(vecs[0]);
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v);
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("v%0d fetch_valid", i), 32'(fetch_valid), 32'(v.ev));
            if (v.ev || v.r) begin
                chk($sformatf("v%0d fetch_pc", i), fetch_pc, v.epc);
                chk($sformatf("v%0d fetch_tid", i), 32'(fetch_tid), 32'(v.et));
            end
            chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'(v.em));
            if (v.em) chk($sformatf("v%0d misalign_tid", i), 32'(misalign_tid), 32'(v.emt));
        end

        for (int k = 0; k < 600; k++) begin
            rst         = (k == 0) || ($urandom_range(0, 199) == 0);
            thread_en   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            halt        = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            fetch_ready = $urandom_range(0, 9) < 7;
            br_valid    = $urandom_range(0, 9) < 2;
            br_tid      = 1'($urandom_range(0, 1));
            br_pc       = ($urandom() & 32'hFFFF_FFFC)
                        | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            trap_valid  = $urandom_range(0, 11) == 0;
            trap_tid    = 1'($urandom_range(0, 1));
            trap_pc     = $urandom();
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("r%0d fetch_valid", k), 32'(fetch_valid), 32'(m_valid));
            if (m_valid) begin
                chk($sformatf("r%0d fetch_pc", k), fetch_pc, m_fpc);
                chk($sformatf("r%0d fetch_tid", k), 32'(fetch_tid), 32'(m_ftid));
            end
            chk($sformatf("r%0d misalign_err", k), 32'(misalign_err), 32'(m_mis));
            if (m_mis) chk($sformatf("r%0d misalign_tid", k), 32'(misalign_tid), 32'(m_mis_tid));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
